// File: rtl/channel_mod_scheduler.sv
// Round-robin burst scheduler sharing one channel_modulator between NUM_CH sources.
// Each grant lasts up to BURST_LEN samples and is followed by GAP_CYCLES guard cycles.
module channel_mod_scheduler #(
    parameter int WIDTH      = 16,
    parameter int NUM_CH     = 4,
    parameter int BURST_LEN  = 64,
    parameter int GAP_CYCLES = 8
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NUM_CH*WIDTH-1:0]   i_in_data,
    input  logic [NUM_CH-1:0]         i_in_valid,
    output logic [NUM_CH-1:0]         o_in_ready,
    output logic [WIDTH-1:0]          o_out_data,
    output logic                      o_out_valid,
    output logic [$clog2(NUM_CH)-1:0] o_out_chan,
    output logic                      o_busy,
    output logic                      o_underrun
);
    localparam int          CW  = $clog2(NUM_CH);
    localparam int          BW  = $clog2(BURST_LEN + 1);
    localparam int          GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned NCH = NUM_CH;

    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_AFTER = (GAP_CYCLES > 0) ? ST_GAP : ST_ARB;

    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    grant_q, grant_d;
    logic [CW-1:0]    last_grant_q, last_grant_d;
    logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic             underrun_q, underrun_d;

    logic [2*NUM_CH-1:0] valid_dbl;
    logic [2*NUM_CH-1:0] valid_rot;
    logic [CW:0]         rot_amt;
    logic [WIDTH-1:0]    sel_data;
    logic                grant_valid;
    logic                found;

    // Rotating a doubled copy puts the source after last_grant at bit 0.
    assign valid_dbl = {i_in_valid, i_in_valid};
    assign rot_amt   = {1'b0, last_grant_q} + 1'b1;
    assign valid_rot = valid_dbl >> rot_amt;

    always_comb begin
        sel_data    = '0;
        grant_valid = 1'b0;
        o_in_ready  = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (grant_q == CW'(k)) begin
                sel_data    = i_in_data[k*WIDTH +: WIDTH];
                grant_valid = i_in_valid[k];
                o_in_ready[k] = (state_q == ST_BURST);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        out_valid_d  = 1'b0;
        underrun_d   = 1'b0;
        found        = 1'b0;
        case (state_q)
            ST_ARB: begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    if (!found && valid_rot[i]) begin
                        found   = 1'b1;
                        grant_d = CW'((32'(last_grant_q) + 32'd1 + i) % NCH);
                    end
                end
                if (found) begin
                    state_d     = ST_BURST;
                    burst_cnt_d = '0;
                end
            end
            ST_BURST: begin
                if (grant_valid) begin
                    out_data_d  = sel_data;
                    out_chan_d  = grant_q;
                    out_valid_d = 1'b1;
                    if (burst_cnt_q == BURST_LAST) begin
                        last_grant_d = grant_q;
                        burst_cnt_d  = '0;
                        gap_cnt_d    = '0;
                        state_d      = ST_AFTER;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else begin
                    underrun_d   = 1'b1;
                    last_grant_d = grant_q;
                    burst_cnt_d  = '0;
                    gap_cnt_d    = '0;
                    state_d      = ST_AFTER;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_ARB;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= ST_ARB;
            grant_q      <= '0;
            last_grant_q <= CW'(NUM_CH - 1);
            burst_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            out_valid_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            out_valid_q  <= out_valid_d;
            underrun_q   <= underrun_d;
        end
    end

    assign o_out_data  = out_data_q;
    assign o_out_chan  = out_chan_q;
    assign o_out_valid = out_valid_q;
    assign o_underrun  = underrun_q;
    assign o_busy      = (state_q != ST_ARB);

endmodule

// File: tb/tb_channel_mod_scheduler.sv
// Scoreboard bench for channel_mod_scheduler: instance A uses default parameters,
// instance B uses BURST_LEN=1, GAP_CYCLES=0. Sources hold data until accepted.
module tb_channel_mod_scheduler;
    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N*W-1:0] in_data_a, in_data_b;
    logic [N-1:0]   in_valid_a, in_valid_b, rdy_a, rdy_b;
    logic [W-1:0]   od_a, od_b;
    logic           ov_a, ov_b, busy_a, busy_b, ur_a, ur_b;
    logic [1:0]     oc_a, oc_b;

    channel_mod_scheduler #(.WIDTH(W), .NUM_CH(N), .BURST_LEN(64), .GAP_CYCLES(8)) u_dut_a (
        .i_clock(clk), .i_reset(rst), .i_in_data(in_data_a), .i_in_valid(in_valid_a),
        .o_in_ready(rdy_a), .o_out_data(od_a), .o_out_valid(ov_a), .o_out_chan(oc_a),
        .o_busy(busy_a), .o_underrun(ur_a)
    );

    channel_mod_scheduler #(.WIDTH(W), .NUM_CH(N), .BURST_LEN(1), .GAP_CYCLES(0)) u_dut_b (
        .i_clock(clk), .i_reset(rst), .i_in_data(in_data_b), .i_in_valid(in_valid_b),
        .o_in_ready(rdy_b), .o_out_data(od_b), .o_out_valid(ov_b), .o_out_chan(oc_b),
        .o_busy(busy_b), .o_underrun(ur_b)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          cyc = 0;
    logic [17:0] exp_a[$];
    logic [17:0] exp_b[$];
    logic [17:0] e_a, e_b;
    int          cyc_a[$];
    int          cyc_b[$];
    int unsigned ur_cnt[2];
    int          first_hs;
    int unsigned n_src[2][N];
    int unsigned lim[2][N];
    bit          plain_a;
    int unsigned idle_bad;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expected {chan,data} per output strobe.
    always @(negedge clk) begin
        if (ov_a) begin
            cyc_a.push_back(cyc);
            if (exp_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL out_a_unexpected: got ch%0d data 0x%0h expected no output", oc_a, od_a);
            end else begin
                e_a = exp_a.pop_front();
                check("out_a", 32'({oc_a, od_a}), 32'(e_a));
            end
        end
        if (ov_b) begin
            cyc_b.push_back(cyc);
            if (exp_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL out_b_unexpected: got ch%0d data 0x%0h expected no output", oc_b, od_b);
            end else begin
                e_b = exp_b.pop_front();
                check("out_b", 32'({oc_b, od_b}), 32'(e_b));
            end
        end
        if (ur_a) ur_cnt[0]++;
        if (ur_b) ur_cnt[1]++;
    end

    task automatic push(input int d, input int unsigned ch, input int unsigned first, input int unsigned cnt, input bit plain);
        for (int unsigned i = 0; i < cnt; i++) begin
            logic [15:0] v;
            v = plain ? 16'(first + i) : 16'((ch << 12) | (first + i));
            if (d == 0) exp_a.push_back({2'(ch), v});
            else        exp_b.push_back({2'(ch), v});
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            in_valid_a[k]       = n_src[0][k] < lim[0][k];
            in_data_a[k*W +: W] = plain_a ? 16'(n_src[0][k]) : 16'((k << 12) | n_src[0][k]);
            in_valid_b[k]       = n_src[1][k] < lim[1][k];
            in_data_b[k*W +: W] = 16'((k << 12) | n_src[1][k]);
        end
    endtask

    task automatic tick();
        bit hs[2][N];
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            hs[0][k] = in_valid_a[k] & rdy_a[k] & !rst;
            hs[1][k] = in_valid_b[k] & rdy_b[k] & !rst;
            if (hs[0][k] && first_hs < 0) first_hs = cyc;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < N; k++)
                if (hs[d][k]) n_src[d][k]++;
        drive();
    endtask

    task automatic do_reset();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < N; k++) begin
                n_src[d][k] = 0;
                lim[d][k]   = 0;
            end
        plain_a = 1'b0;
        drive();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc_a.delete();
        cyc_b.delete();
        ur_cnt[0] = 0;
        ur_cnt[1] = 0;
        first_hs  = -1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 3000) begin
            tick();
            t++;
        end
        check("drain_a", exp_a.size(), 0);
        check("drain_b", exp_b.size(), 0);
        repeat (30) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1'b1;
        in_valid_a = '0; in_valid_b = '0; in_data_a = '0; in_data_b = '0;
        do_reset();

        // Reset values and idle behaviour
        check("rst_data", od_a, 0);
        check("rst_valid", ov_a, 0);
        check("rst_chan", oc_a, 0);
        check("rst_underrun", ur_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ready", rdy_a, 0);
        idle_bad = 0;
        repeat (1000) begin
            tick();
            if (ov_a || busy_a || rdy_a != 0) idle_bad++;
        end
        check("idle_bad", idle_bad, 0);

        // Single source ch2, counter data, two bursts
        do_reset();
        plain_a = 1'b1;
        lim[0][2] = 128;
        drive();
        push(0, 2, 0, 128, 1'b1);
        drain();
        check("t2_count", cyc_a.size(), 128);
        check("t2_latency", 32'(cyc_a[0] - first_hs), 1);
        check("t2_burst1_span", 32'(cyc_a[63] - cyc_a[0]), 63);
        check("t2_gap", 32'(cyc_a[64] - cyc_a[63]), 10);
        check("t2_burst2_span", 32'(cyc_a[127] - cyc_a[64]), 63);
        check("t2_underrun", ur_cnt[0], 0);

        // Round robin across all four sources
        do_reset();
        lim[0][0] = 128; lim[0][1] = 64; lim[0][2] = 64; lim[0][3] = 64;
        drive();
        push(0, 0, 0, 64, 1'b0);
        push(0, 1, 0, 64, 1'b0);
        push(0, 2, 0, 64, 1'b0);
        push(0, 3, 0, 64, 1'b0);
        push(0, 0, 64, 64, 1'b0);
        drain();
        check("t3_underrun", ur_cnt[0], 0);

        // Underrun: ch1 stops after 10 samples, ch2 is next
        do_reset();
        lim[0][1] = 10; lim[0][2] = 64;
        drive();
        push(0, 1, 0, 10, 1'b0);
        push(0, 2, 0, 64, 1'b0);
        drain();
        check("t4_underrun", ur_cnt[0], 1);

        // Reset in the middle of ch1's burst
        do_reset();
        for (int k = 0; k < N; k++) lim[0][k] = 1000;
        drive();
        push(0, 0, 0, 64, 1'b0);
        push(0, 1, 0, 30, 1'b0);
        t = 0;
        while (n_src[0][1] != 30 && t < 500) begin
            tick();
            t++;
        end
        check("t5_reach30", n_src[0][1], 30);
        rst = 1'b1;
        tick();
        check("t5_valid", ov_a, 0);
        check("t5_ready", rdy_a, 0);
        check("t5_busy", busy_a, 0);
        lim[0][0] = 69; lim[0][1] = 33; lim[0][2] = 0; lim[0][3] = 0;
        drive();
        rst = 1'b0;
        push(0, 0, 64, 5, 1'b0);
        push(0, 1, 30, 3, 1'b0);
        drain();

        // BURST_LEN=1, GAP_CYCLES=0 instance: one sample per grant
        do_reset();
        for (int k = 0; k < N; k++) lim[1][k] = 3;
        drive();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < N; k++)
                push(1, k, r, 1, 1'b0);
        drain();
        check("t6_count", cyc_b.size(), 12);
        for (int i = 0; i < 11; i++)
            check("t6_spacing", 32'(cyc_b[i+1] - cyc_b[i]), 2);
        check("t6_underrun", ur_cnt[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
